// File: rtl/ibex_ahb_arbiter_if.sv
// Bundle of the Ibex instruction/data request-grant ports and the AHB-Lite master port.
// The arbiter uses the master modport; the core/interconnect side uses slave.
interface ibex_ahb_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output HADDR, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  HADDR, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ibex_ahb_arbiter.sv
// Round-robin share of one AHB-Lite master port between Ibex fetch and LSU.
// state | meaning:  IDLE = arbitrate/grant, ADDR = NONSEQ address phase, DATA = data phase / response
module ibex_ahb_arbiter #(
    parameter bit RESET_LAST_DATA = 1'b1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ibex_ahb_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;

    state_t      state, state_next;
    logic        last_data;
    logic        owner_data;
    logic        cap_we;
    logic        cap_reject;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_size;

    logic        gnt_instr, gnt_data, reject_now, rsp;
    logic [2:0]  dec_size;
    logic [1:0]  dec_off;
    logic        dec_illegal;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.instr_addr_i[1:0], bus.data_addr_i[1:0]};

    always_comb begin
        dec_size    = 3'b010;
        dec_off     = 2'd0;
        dec_illegal = 1'b0;
        case (bus.data_be_i)
            4'b0001: begin dec_size = 3'b000; dec_off = 2'd0; end
            4'b0010: begin dec_size = 3'b000; dec_off = 2'd1; end
            4'b0100: begin dec_size = 3'b000; dec_off = 2'd2; end
            4'b1000: begin dec_size = 3'b000; dec_off = 2'd3; end
            4'b0011: begin dec_size = 3'b001; dec_off = 2'd0; end
            4'b1100: begin dec_size = 3'b001; dec_off = 2'd2; end
            4'b1111: begin dec_size = 3'b010; dec_off = 2'd0; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // On a tie the port that did not own the bus last wins
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (state == IDLE && !HRESET) begin
            if (bus.instr_req_i && (!bus.data_req_i || last_data))
                gnt_instr = 1'b1;
            else if (bus.data_req_i)
                gnt_data = 1'b1;
        end
    end

    assign reject_now = gnt_data & bus.data_we_i & dec_illegal;

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (gnt_instr || gnt_data) state_next = reject_now ? DATA : ADDR;
            ADDR: if (bus.HREADY) state_next = DATA;
            DATA: if (cap_reject || bus.HREADY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_data  <= RESET_LAST_DATA;
            owner_data <= 1'b0;
            cap_we     <= 1'b0;
            cap_reject <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_size   <= 3'b010;
        end else if (gnt_data) begin
            last_data  <= 1'b1;
            owner_data <= 1'b1;
            cap_we     <= bus.data_we_i;
            cap_reject <= reject_now;
            cap_addr   <= {bus.data_addr_i[31:2], dec_off};
            cap_wdata  <= bus.data_we_i ? bus.data_wdata_i : 32'd0;
            cap_size   <= dec_size;
        end else if (gnt_instr) begin
            last_data  <= 1'b0;
            owner_data <= 1'b0;
            cap_we     <= 1'b0;
            cap_reject <= 1'b0;
            cap_addr   <= {bus.instr_addr_i[31:2], 2'b00};
            cap_wdata  <= 32'd0;
            cap_size   <= 3'b010;
        end
    end

    // A rejected write answers unconditionally; a real transfer waits for HREADY
    assign rsp = (state == DATA) && !HRESET && (cap_reject || bus.HREADY);

    always_comb begin
        bus.instr_gnt_o    = gnt_instr;
        bus.data_gnt_o     = gnt_data;
        bus.instr_rvalid_o = rsp & ~owner_data;
        bus.data_rvalid_o  = rsp & owner_data;
        bus.instr_err_o    = rsp & ~owner_data & bus.HRESP;
        bus.data_err_o     = rsp & owner_data & (cap_reject | bus.HRESP);
        bus.instr_rdata_o  = (rsp && !owner_data) ? bus.HRDATA : 32'd0;
        bus.data_rdata_o   = (rsp && owner_data && !cap_reject) ? bus.HRDATA : 32'd0;
        bus.HTRANS         = (state == ADDR) ? 2'b10 : 2'b00;
        bus.HADDR          = cap_addr;
        bus.HSIZE          = cap_size;
        bus.HWRITE         = cap_we;
        bus.HWDATA         = cap_wdata;
    end
endmodule

// File: tb/tb_ibex_ahb_arbiter.sv
// Scenario bench for ibex_ahb_arbiter: expected responses are queued at request time
// and popped when the owning port's rvalid fires.
module tb_ibex_ahb_arbiter;
    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ibex_ahb_arbiter_if bus ();
    ibex_ahb_arbiter #(.RESET_LAST_DATA(1'b1)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    typedef struct {logic port; logic [31:0] rdata; logic err;} exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [8:0] DEC_TBL [7] = '{
        {4'b0001, 3'b000, 2'd0}, {4'b0010, 3'b000, 2'd1}, {4'b1000, 3'b000, 2'd3},
        {4'b0011, 3'b001, 2'd0}, {4'b1100, 3'b001, 2'd2}, {4'b1111, 3'b010, 2'd0},
        {4'b0110, 3'b010, 2'd0}};

    task automatic idle_inputs();
        bus.instr_req_i  = 1'b0; bus.instr_addr_i = 32'd0;
        bus.data_req_i   = 1'b0; bus.data_we_i    = 1'b0; bus.data_be_i = 4'hF;
        bus.data_addr_i  = 32'd0; bus.data_wdata_i = 32'd0;
        bus.HRDATA = 32'd0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        idle_inputs();
        bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1;
        repeat (2) @(negedge HCLK);
        #1;
        n_checks++;
        if ({bus.HTRANS, bus.HSIZE, bus.HWRITE} !== {2'b00, 3'b010, 1'b0}) begin
            n_fail++; $display("FAIL reset_ctrl: got trans/size/write %b/%b/%b expected 00/010/0", bus.HTRANS, bus.HSIZE, bus.HWRITE);
        end
        n_checks++;
        if ({bus.HADDR, bus.HWDATA} !== 64'd0) begin
            n_fail++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus.HADDR, bus.HWDATA);
        end
        n_checks++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o} !== 6'd0) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 000000",
                {bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o});
        end
        n_checks++;
        if ({bus.instr_rdata_o, bus.data_rdata_o} !== 64'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.instr_rdata_o, bus.data_rdata_o);
        end
        @(negedge HCLK);
        idle_inputs();
        HRESET = 1'b0;
    endtask

    task automatic test_single_fetch();
        exp_t e;
        @(negedge HCLK);
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0104;
        #1;
        n_checks++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_gnt: got %b expected 10", {bus.instr_gnt_o, bus.data_gnt_o});
        end
        sb.push_back('{port: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge HCLK);
        bus.instr_req_i = 1'b0; bus.HRDATA = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({bus.HTRANS, bus.HSIZE, bus.HADDR, bus.instr_gnt_o} !== {2'b10, 3'b010, 32'h104, 1'b0}) begin
            n_fail++; $display("FAIL fetch_addr_phase: got trans %b size %b addr %h gnt %b expected 10 010 00000104 0",
                bus.HTRANS, bus.HSIZE, bus.HADDR, bus.instr_gnt_o);
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if (bus.instr_rvalid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL fetch_rvalid: got %b expected 1", bus.instr_rvalid_o);
        end else begin
            e = sb.pop_front();
            if (e.port !== 1'b0 || bus.instr_rdata_o !== e.rdata || bus.instr_err_o !== e.err) begin
                n_fail++; $display("FAIL fetch_rdata: got %h err %b expected %h err %b", bus.instr_rdata_o, bus.instr_err_o, e.rdata, e.err);
            end
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if ({bus.instr_rvalid_o, bus.HTRANS} !== 3'b000) begin
            n_fail++; $display("FAIL fetch_after: got rvalid %b trans %b expected 0 00", bus.instr_rvalid_o, bus.HTRANS);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic exp_port;
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0400;
        bus.data_req_i  = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h0000_0800;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge HCLK);
            bus.HRDATA = 32'hC0DE_0000 + 32'(k / 3);
            exp_port = ((k / 3) % 2) == 1;
            #1;
            n_checks++;
            if ({bus.instr_gnt_o, bus.data_gnt_o} !== ((k % 3 == 0) ? {~exp_port, exp_port} : 2'b00)) begin
                n_fail++; $display("FAIL contention_gnt[%0d]: got %b expected port %0d granted only on k%%3==0", k,
                    {bus.instr_gnt_o, bus.data_gnt_o}, exp_port);
            end
            if (k % 3 == 0) sb.push_back('{port: exp_port, rdata: 32'hC0DE_0000 + 32'(k / 3), err: 1'b0});
            if (k % 3 == 1) begin
                n_checks++;
                if ({bus.HTRANS, bus.HADDR} !== {2'b10, (exp_port ? 32'h800 : 32'h400)}) begin
                    n_fail++; $display("FAIL contention_addr[%0d]: got %b %h", k, bus.HTRANS, bus.HADDR);
                end
            end
            if (k % 3 == 2) begin
                n_checks++;
                if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== {~exp_port, exp_port} || sb.size() == 0) begin
                    n_fail++; $display("FAIL contention_rvalid[%0d]: got %b expected port %0d", k,
                        {bus.instr_rvalid_o, bus.data_rvalid_o}, exp_port);
                end else begin
                    e = sb.pop_front();
                    if ((e.port ? bus.data_rdata_o : bus.instr_rdata_o) !== e.rdata || e.port !== exp_port) begin
                        n_fail++; $display("FAIL contention_rdata[%0d]: got %h/%h expected %h", k,
                            bus.instr_rdata_o, bus.data_rdata_o, e.rdata);
                    end
                end
            end
        end
        @(negedge HCLK);
        idle_inputs();
    endtask

    task automatic test_byte_store();
        exp_t e;
        @(negedge HCLK);
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0100;
        bus.data_addr_i = 32'h2000_0010; bus.data_wdata_i = 32'h00AB_0000;
        #1;
        n_checks++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01) begin
            n_fail++; $display("FAIL store_gnt: got %b expected 01", {bus.instr_gnt_o, bus.data_gnt_o});
        end
        sb.push_back('{port: 1'b1, rdata: 32'd0, err: 1'b0});
        @(negedge HCLK);
        idle_inputs();
        #1;
        n_checks++;
        if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE} !== {2'b10, 32'h2000_0012, 3'b000, 1'b1}) begin
            n_fail++; $display("FAIL store_addr_phase: got trans %b addr %h size %b write %b expected 10 20000012 000 1",
                bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE);
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if (bus.HWDATA !== 32'h00AB_0000 || bus.HTRANS !== 2'b00) begin
            n_fail++; $display("FAIL store_wdata: got %h trans %b expected 00ab0000 00", bus.HWDATA, bus.HTRANS);
        end
        n_checks++;
        if (bus.data_rvalid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL store_rvalid: got %b expected 1", bus.data_rvalid_o);
        end else begin
            e = sb.pop_front();
            if (e.port !== 1'b1 || bus.data_err_o !== e.err) begin
                n_fail++; $display("FAIL store_err: got %b expected %b", bus.data_err_o, e.err);
            end
        end
    endtask

    task automatic test_be_decode();
        exp_t e;
        logic [31:0] base;
        for (int i = 0; i < 7; i++) begin
            base = 32'h1000_0040 + 32'(i * 16);
            @(negedge HCLK);
            bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = DEC_TBL[i][8:5];
            bus.data_addr_i = base | 32'd3;
            #1;
            n_checks++;
            if (bus.data_gnt_o !== 1'b1) begin
                n_fail++; $display("FAIL decode_gnt[%0d]: got %b expected 1", i, bus.data_gnt_o);
            end
            sb.push_back('{port: 1'b1, rdata: 32'hA0 + 32'(i), err: 1'b0});
            @(negedge HCLK);
            bus.data_req_i = 1'b0; bus.HRDATA = 32'hA0 + 32'(i);
            #1;
            n_checks++;
            if ({bus.HTRANS, bus.HSIZE, bus.HADDR, bus.HWRITE} !== {2'b10, DEC_TBL[i][4:2], base | 32'(DEC_TBL[i][1:0]), 1'b0}) begin
                n_fail++; $display("FAIL decode_addr[%0d]: got trans %b size %b addr %h write %b expected size %b addr %h",
                    i, bus.HTRANS, bus.HSIZE, bus.HADDR, bus.HWRITE, DEC_TBL[i][4:2], base | 32'(DEC_TBL[i][1:0]));
            end
            @(negedge HCLK);
            #1;
            n_checks++;
            if (bus.data_rvalid_o !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL decode_rvalid[%0d]: got %b expected 1", i, bus.data_rvalid_o);
            end else begin
                e = sb.pop_front();
                if (bus.data_rdata_o !== e.rdata || bus.data_err_o !== e.err) begin
                    n_fail++; $display("FAIL decode_rdata[%0d]: got %h expected %h", i, bus.data_rdata_o, e.rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_wait_error();
        exp_t e;
        @(negedge HCLK);
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0200; bus.HREADY = 1'b0;
        #1;
        n_checks++;
        if (bus.instr_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL wait_gnt: got %b expected 1", bus.instr_gnt_o);
        end
        sb.push_back('{port: 1'b0, rdata: 32'd0, err: 1'b1});
        for (int c = 1; c <= 4; c++) begin
            @(negedge HCLK);
            bus.instr_req_i = 1'b0;
            bus.HREADY = (c == 3);
            bus.HRESP  = (c == 4);
            #1;
            n_checks++;
            if ({bus.HTRANS, bus.HADDR, bus.instr_rvalid_o, bus.instr_gnt_o} !== {(c <= 3) ? 2'b10 : 2'b00, 32'h200, 2'b00}) begin
                n_fail++; $display("FAIL wait_cycle[%0d]: got trans %b addr %h rvalid %b gnt %b", c,
                    bus.HTRANS, bus.HADDR, bus.instr_rvalid_o, bus.instr_gnt_o);
            end
        end
        @(negedge HCLK);
        bus.HREADY = 1'b1; bus.HRESP = 1'b1; bus.HRDATA = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (bus.instr_rvalid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL wait_rvalid_c5: got %b expected 1", bus.instr_rvalid_o);
        end else begin
            e = sb.pop_front();
            if (e.port !== 1'b0 || bus.instr_err_o !== e.err) begin
                n_fail++; $display("FAIL wait_err: got %b expected %b", bus.instr_err_o, e.err);
            end
        end
        @(negedge HCLK);
        idle_inputs();
        #1;
        n_checks++;
        if ({bus.instr_rvalid_o, bus.instr_err_o, bus.HTRANS} !== 4'b0000) begin
            n_fail++; $display("FAIL wait_idle: got rvalid %b err %b trans %b expected 0 0 00",
                bus.instr_rvalid_o, bus.instr_err_o, bus.HTRANS);
        end
    endtask

    task automatic test_illegal_write();
        exp_t e;
        @(negedge HCLK);
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0110;
        bus.data_addr_i = 32'h0000_0030; bus.data_wdata_i = 32'h0000_1234;
        #1;
        n_checks++;
        if ({bus.data_gnt_o, bus.HTRANS} !== 3'b100) begin
            n_fail++; $display("FAIL illegal_gnt: got gnt %b trans %b expected 1 00", bus.data_gnt_o, bus.HTRANS);
        end
        sb.push_back('{port: 1'b1, rdata: 32'd0, err: 1'b1});
        @(negedge HCLK);
        idle_inputs();
        bus.HREADY = 1'b0;
        #1;
        n_checks++;
        if (bus.HTRANS !== 2'b00) begin
            n_fail++; $display("FAIL illegal_no_nonseq: got %b expected 00", bus.HTRANS);
        end
        n_checks++;
        if (bus.data_rvalid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL illegal_rvalid: got %b expected 1", bus.data_rvalid_o);
        end else begin
            e = sb.pop_front();
            if (e.port !== 1'b1 || bus.data_err_o !== e.err) begin
                n_fail++; $display("FAIL illegal_err: got %b expected %b", bus.data_err_o, e.err);
            end
        end
        @(negedge HCLK);
        bus.HREADY = 1'b1;
        #1;
        n_checks++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.HTRANS} !== 4'b0000) begin
            n_fail++; $display("FAIL illegal_after: got rvalid %b err %b trans %b expected 0 0 00",
                bus.data_rvalid_o, bus.data_err_o, bus.HTRANS);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge HCLK);
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h0000_0044;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", bus.data_gnt_o);
        end
        @(negedge HCLK);
        idle_inputs();
        bus.HRDATA = 32'h1111_2222;
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        n_checks++;
        if ({bus.data_rvalid_o, bus.instr_rvalid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_no_rvalid: got %b expected 00", {bus.data_rvalid_o, bus.instr_rvalid_o});
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        n_checks++;
        if ({bus.HTRANS, bus.HADDR, bus.data_rvalid_o} !== {2'b00, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_idle: got trans %b addr %h rvalid %b expected 00 0 0",
                bus.HTRANS, bus.HADDR, bus.data_rvalid_o);
        end
        @(negedge HCLK);
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0500;
        #1;
        n_checks++;
        if (bus.instr_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_regrant: got %b expected 1", bus.instr_gnt_o);
        end
        sb.push_back('{port: 1'b0, rdata: 32'h5A5A_0001, err: 1'b0});
        @(negedge HCLK);
        bus.instr_req_i = 1'b0; bus.HRDATA = 32'h5A5A_0001;
        @(negedge HCLK);
        #1;
        n_checks++;
        if (bus.instr_rvalid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL rstmid_rvalid: got %b expected 1", bus.instr_rvalid_o);
        end else begin
            e = sb.pop_front();
            if (bus.instr_rdata_o !== e.rdata) begin
                n_fail++; $display("FAIL rstmid_rdata: got %h expected %h", bus.instr_rdata_o, e.rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_byte_store();
        test_be_decode();
        test_wait_error();
        test_illegal_write();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
